// File: rtl/lfsr_pkg.sv
// Shared LFSR constants: topology selectors, default maximal-length tap masks
// for widths 2..32, and the one-step next-state function used by lfsr_step.
package lfsr_pkg;

    localparam int unsigned MAX_WIDTH = 32;
    localparam int unsigned MODE_FIB  = 0;
    localparam int unsigned MODE_GAL  = 1;

    // Bit i set = state bit i feeds back (polynomial exponent i+1).
    localparam logic [1:0]  TAPS_W2  = 2'h3;
    localparam logic [2:0]  TAPS_W3  = 3'h6;
    localparam logic [3:0]  TAPS_W4  = 4'hC;
    localparam logic [4:0]  TAPS_W5  = 5'h14;
    localparam logic [5:0]  TAPS_W6  = 6'h30;
    localparam logic [6:0]  TAPS_W7  = 7'h60;
    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [8:0]  TAPS_W9  = 9'h110;
    localparam logic [9:0]  TAPS_W10 = 10'h240;
    localparam logic [10:0] TAPS_W11 = 11'h500;
    localparam logic [11:0] TAPS_W12 = 12'hE08;
    localparam logic [12:0] TAPS_W13 = 13'h1C80;
    localparam logic [13:0] TAPS_W14 = 14'h3802;
    localparam logic [14:0] TAPS_W15 = 15'h6000;
    localparam logic [15:0] TAPS_W16 = 16'hB400;
    localparam logic [16:0] TAPS_W17 = 17'h12000;
    localparam logic [17:0] TAPS_W18 = 18'h20400;
    localparam logic [18:0] TAPS_W19 = 19'h72000;
    localparam logic [19:0] TAPS_W20 = 20'h90000;
    localparam logic [20:0] TAPS_W21 = 21'h140000;
    localparam logic [21:0] TAPS_W22 = 22'h300000;
    localparam logic [22:0] TAPS_W23 = 23'h420000;
    localparam logic [23:0] TAPS_W24 = 24'hE10000;
    localparam logic [24:0] TAPS_W25 = 25'h1200000;
    localparam logic [25:0] TAPS_W26 = 26'h2000023;
    localparam logic [26:0] TAPS_W27 = 27'h4000013;
    localparam logic [27:0] TAPS_W28 = 28'h9000000;
    localparam logic [28:0] TAPS_W29 = 29'h14000000;
    localparam logic [29:0] TAPS_W30 = 30'h20000029;
    localparam logic [30:0] TAPS_W31 = 31'h48000000;
    localparam logic [31:0] TAPS_W32 = 32'h80200003;

    // Operands are zero-extended to MAX_WIDTH; callers truncate back to their width.
    function automatic logic [MAX_WIDTH-1:0] lfsr_next(
        input logic [MAX_WIDTH-1:0] state,
        input logic [MAX_WIDTH-1:0] taps,
        input logic                 mode
    );
        logic [MAX_WIDTH-1:0] nxt;
        if (mode) begin
            nxt = (state >> 1) ^ (state[0] ? taps : '0);
        end else begin
            nxt = {state[MAX_WIDTH-2:0], ^(state & taps)};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational LFSR next-state and all-zero detect for one configured width/topology.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8),
    parameter int unsigned      MODE  = MODE_FIB
) (
    input  logic [WIDTH-1:0] state_i,
    output logic [WIDTH-1:0] next_c_o,
    output logic             zero_c_o
);

    assign next_c_o = WIDTH'(lfsr_next(MAX_WIDTH'(state_i), MAX_WIDTH'(TAPS), MODE == MODE_GAL));
    assign zero_c_o = (state_i == '0);

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR generator with seed load, lock-up recovery and wrap pulse.
// Define LFSR_PERIOD_CNT_EN to add the step counter and the period output.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(8'hB8),
    parameter int unsigned      MODE       = MODE_FIB,
    parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] state,
    output logic             bit_out,
    output logic             wrap,
    output logic             lockup
`ifdef LFSR_PERIOD_CNT_EN
    ,
    output logic [WIDTH-1:0] period
`endif
);

    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("lfsr_gen: WIDTH must be in 2..32");
    end
    if (RESET_SEED == '0) begin : g_bad_seed
        $error("lfsr_gen: RESET_SEED must be non-zero");
    end

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic             wrap_q, wrap_d;
    logic             lockup_q, lockup_d;
    logic [WIDTH-1:0] next_c;
    logic             zero_c;
`ifdef LFSR_PERIOD_CNT_EN
    logic [WIDTH-1:0] step_cnt_q, step_cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
`endif

    lfsr_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .MODE  (MODE)
    ) u_step (
        .state_i  (state_q),
        .next_c_o (next_c),
        .zero_c_o (zero_c)
    );

    // Priority: load > en > hold; reset overrides everything in the register.
    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        wrap_d   = 1'b0;
        lockup_d = 1'b0;
`ifdef LFSR_PERIOD_CNT_EN
        step_cnt_d = step_cnt_q;
        period_d   = period_q;
`endif
        if (load) begin
            if (seed == '0) begin
                state_d  = WIDTH'(1);
                start_d  = WIDTH'(1);
                lockup_d = 1'b1;
            end else begin
                state_d = seed;
                start_d = seed;
            end
`ifdef LFSR_PERIOD_CNT_EN
            step_cnt_d = '0;
`endif
        end else if (en) begin
            // A zero state would stick forever; recovery beats wrap evaluation.
            if (zero_c) begin
                state_d  = WIDTH'(1);
                lockup_d = 1'b1;
            end else begin
                state_d = next_c;
                wrap_d  = (next_c == start_q);
            end
`ifdef LFSR_PERIOD_CNT_EN
            if (wrap_d) begin
                period_d   = step_cnt_q + WIDTH'(1);
                step_cnt_d = '0;
            end else begin
                step_cnt_d = step_cnt_q + WIDTH'(1);
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RESET_SEED;
            start_q  <= RESET_SEED;
            wrap_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            wrap_q   <= wrap_d;
            lockup_q <= lockup_d;
        end
    end

`ifdef LFSR_PERIOD_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            step_cnt_q <= '0;
            period_q   <= '0;
        end else begin
            step_cnt_q <= step_cnt_d;
            period_q   <= period_d;
        end
    end

    assign period = period_q;
`endif

    assign state   = state_q;
    assign bit_out = state_q[WIDTH-1];
    assign wrap    = wrap_q;
    assign lockup  = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: 3-bit Fibonacci/Galois/zero-tap instances share
// directed controls; an 8-bit instance runs two full maximal-length periods.
module tb_lfsr_gen;

`ifdef LFSR_PERIOD_CNT_EN
    localparam bit PER_EN = 1'b1;
`else
    localparam bit PER_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] st;
        logic       st_vld;
        logic       wr;
        logic       lk;
        logic [7:0] per;
    } exp_t;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst3, en3, ld3;
    logic [2:0] seed3;
    logic       rst8, en8;

    logic [2:0] st_f, st_g, st_z, per_f, per_g, per_z;
    logic       bo_f, bo_g, bo_z, wr_f, wr_g, wr_z, lk_f, lk_g, lk_z;
    logic [7:0] st_8, per_8;
    logic       bo_8, wr_8, lk_8;

    exp_t q_f[$];
    exp_t q_g[$];
    exp_t q_z[$];
    exp_t q_8[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [2:0] p3 = 3'd0;

`ifndef LFSR_PERIOD_CNT_EN
    assign per_f = '0;
    assign per_g = '0;
    assign per_z = '0;
    assign per_8 = '0;
`endif

    lfsr_gen #(.WIDTH(3), .TAPS(3'b110), .MODE(0), .RESET_SEED(3'b001)) u_fib3 (
        .clk(clk), .reset(rst3), .en(en3), .load(ld3), .seed(seed3),
        .state(st_f), .bit_out(bo_f), .wrap(wr_f), .lockup(lk_f)
`ifdef LFSR_PERIOD_CNT_EN
        , .period(per_f)
`endif
    );

    lfsr_gen #(.WIDTH(3), .TAPS(3'b110), .MODE(1), .RESET_SEED(3'b001)) u_gal3 (
        .clk(clk), .reset(rst3), .en(en3), .load(ld3), .seed(seed3),
        .state(st_g), .bit_out(bo_g), .wrap(wr_g), .lockup(lk_g)
`ifdef LFSR_PERIOD_CNT_EN
        , .period(per_g)
`endif
    );

    // Zero tap mask shifts the state down to 0, exercising the lock-up guard.
    lfsr_gen #(.WIDTH(3), .TAPS(3'b000), .MODE(0), .RESET_SEED(3'b001)) u_zero3 (
        .clk(clk), .reset(rst3), .en(en3), .load(ld3), .seed(seed3),
        .state(st_z), .bit_out(bo_z), .wrap(wr_z), .lockup(lk_z)
`ifdef LFSR_PERIOD_CNT_EN
        , .period(per_z)
`endif
    );

    lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .MODE(0), .RESET_SEED(8'h01)) u_fib8 (
        .clk(clk), .reset(rst8), .en(en8), .load(1'b0), .seed(8'h00),
        .state(st_8), .bit_out(bo_8), .wrap(wr_8), .lockup(lk_8)
`ifdef LFSR_PERIOD_CNT_EN
        , .period(per_8)
`endif
    );

    task automatic cmp(input string nm, input exp_t e, input logic [7:0] st, input logic bo,
                       input logic wr, input logic lk, input logic [7:0] per, input int msb);
        logic ok;
        checks++;
        if (e.st_vld) ok = (st === e.st) && (bo === e.st[msb]);
        else          ok = (st !== 8'h00) && !$isunknown(st) && (bo === st[msb]);
        ok = ok && (wr === e.wr) && (lk === e.lk) && (per === e.per);
        if (!ok) begin
            errors++;
            $display("FAIL %s cyc=%0d got state=%h bit=%b wrap=%b lockup=%b period=%h want state=%h(vld=%b) wrap=%b lockup=%b period=%h",
                     nm, cyc, st, bo, wr, lk, per, e.st, e.st_vld, e.wr, e.lk, e.per);
        end
    endtask

    // One cycle of 3-bit stimulus; expectations apply after the next edge.
    task automatic drive3(input logic r, input logic e, input logic l, input logic [2:0] s,
                          input logic [2:0] xf, input logic [2:0] xg, input logic [2:0] xz,
                          input logic wr, input logic lk, input logic lkz);
        exp_t ef, eg, ez;
        @(posedge clk);
        #2;
        rst3 = r; en3 = e; ld3 = l; seed3 = s;
        if (r) p3 = 3'd0;
        else if (wr) p3 = 3'd7;
        ef = '{st: {5'd0, xf}, st_vld: 1'b1, wr: wr, lk: lk, per: PER_EN ? {5'd0, p3} : 8'd0};
        eg = '{st: {5'd0, xg}, st_vld: 1'b1, wr: wr, lk: lk, per: PER_EN ? {5'd0, p3} : 8'd0};
        ez = '{st: {5'd0, xz}, st_vld: 1'b1, wr: 1'b0, lk: lk | lkz, per: 8'd0};
        q_f.push_back(ef);
        q_g.push_back(eg);
        q_z.push_back(ez);
    endtask

    task automatic drive8(input logic r, input logic e, input logic [7:0] xs, input logic vld,
                          input logic wr, input logic [7:0] per);
        exp_t x;
        @(posedge clk);
        #2;
        rst8 = r; en8 = e;
        x = '{st: xs, st_vld: vld, wr: wr, lk: 1'b0, per: PER_EN ? per : 8'd0};
        q_8.push_back(x);
    endtask

    // Monitor: outputs are valid every cycle, sampled 1 time unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q_f.size() > 0) begin e = q_f.pop_front(); cmp("fib3", e, {5'd0, st_f}, bo_f, wr_f, lk_f, {5'd0, per_f}, 2); end
            if (q_g.size() > 0) begin e = q_g.pop_front(); cmp("gal3", e, {5'd0, st_g}, bo_g, wr_g, lk_g, {5'd0, per_g}, 2); end
            if (q_z.size() > 0) begin e = q_z.pop_front(); cmp("zero3", e, {5'd0, st_z}, bo_z, wr_z, lk_z, {5'd0, per_z}, 2); end
            if (q_8.size() > 0) begin e = q_8.pop_front(); cmp("fib8", e, st_8, bo_8, wr_8, lk_8, per_8, 7); end
        end
    end

    initial begin
        logic [2:0] fa [7];
        logic [2:0] ga [7];
        logic [2:0] za [7];
        logic [2:0] fc [7];
        logic [2:0] gc [7];
        fa = '{3'd2, 3'd5, 3'd3, 3'd7, 3'd6, 3'd4, 3'd1};
        ga = '{3'd6, 3'd3, 3'd7, 3'd5, 3'd4, 3'd2, 3'd1};
        za = '{3'd2, 3'd4, 3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
        fc = '{3'd3, 3'd7, 3'd6, 3'd4, 3'd1, 3'd2, 3'd5};
        gc = '{3'd4, 3'd2, 3'd1, 3'd6, 3'd3, 3'd7, 3'd5};

        rst3 = 1'b1; en3 = 1'b0; ld3 = 1'b0; seed3 = 3'd0;
        rst8 = 1'b1; en8 = 1'b0;

        fork
            begin
                drive3(1'b1, 1'b0, 1'b0, 3'd0, 3'd1, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0);
                drive3(1'b1, 1'b0, 1'b0, 3'd0, 3'd1, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0);
                for (int i = 0; i < 7; i++)
                    drive3(1'b0, 1'b1, 1'b0, 3'd0, fa[i], ga[i], za[i], i == 6, 1'b0, i == 3);
                for (int i = 0; i < 2; i++)
                    drive3(1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0);
                // Load together with en: load wins, then a full period back to the seed.
                drive3(1'b0, 1'b1, 1'b1, 3'd5, 3'd5, 3'd5, 3'd5, 1'b0, 1'b0, 1'b0);
                for (int i = 0; i < 7; i++)
                    drive3(1'b0, 1'b1, 1'b0, 3'd0, fc[i], gc[i], za[i], i == 6, 1'b0, i == 3);
                drive3(1'b0, 1'b0, 1'b1, 3'd0, 3'd1, 3'd1, 3'd1, 1'b0, 1'b1, 1'b0);
                drive3(1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0);
                for (int i = 0; i < 3; i++)
                    drive3(1'b0, 1'b1, 1'b0, 3'd0, fa[i], ga[i], za[i], 1'b0, 1'b0, 1'b0);
                for (int i = 0; i < 2; i++)
                    drive3(1'b0, 1'b0, 1'b0, 3'd0, 3'd3, 3'd7, 3'd0, 1'b0, 1'b0, 1'b0);
                drive3(1'b0, 1'b1, 1'b0, 3'd0, 3'd7, 3'd5, 3'd1, 1'b0, 1'b0, 1'b1);
                drive3(1'b0, 1'b0, 1'b1, 3'd6, 3'd6, 3'd6, 3'd6, 1'b0, 1'b0, 1'b0);
                // Reset beats a pending load+step and restores the start reference.
                drive3(1'b1, 1'b1, 1'b1, 3'd3, 3'd1, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0);
                for (int i = 0; i < 7; i++)
                    drive3(1'b0, 1'b1, 1'b0, 3'd0, fa[i], ga[i], za[i], i == 6, 1'b0, i == 3);
                drive3(1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0);
            end
            begin
                drive8(1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 8'd0);
                for (int k = 1; k <= 510; k++)
                    drive8(1'b0, 1'b1, (k % 255 == 0) ? 8'h01 : 8'h00, k % 255 == 0,
                           k % 255 == 0, (k >= 255) ? 8'd255 : 8'd0);
                for (int k = 0; k < 3; k++)
                    drive8(1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 8'd255);
                drive8(1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 8'd255);
                drive8(1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 8'd0);
                drive8(1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 8'd0);
            end
        join

        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (q_f.size() + q_g.size() + q_z.size() + q_8.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending entries want 0",
                     q_f.size() + q_g.size() + q_z.size() + q_8.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
